// File: rtl/menu_nav_ctrl_if.sv
// Front-panel menu bus: key pulses in, menu position and field banks out.
// master = key source / display side, slave = menu_nav_ctrl.
interface menu_nav_ctrl_if #(
  parameter int unsigned N_FIELDS = 4,
  parameter int unsigned FIELD_W  = 2,
  parameter int unsigned ITEM_W   = 2,
  parameter int unsigned FIDX_W   = 3
);
  logic                        left;
  logic                        right;
  logic                        up;
  logic                        down;
  logic                        confirm;
  logic                        quit;
  logic [1:0]                  level;
  logic [ITEM_W-1:0]           item_sel;
  logic [FIDX_W-1:0]           field_sel;
  logic [N_FIELDS*FIELD_W-1:0] field_vals;
  logic [N_FIELDS*FIELD_W-1:0] applied_vals;
  logic                        apply_pulse;
  logic                        running;

  modport master (
    output left, right, up, down, confirm, quit,
    input  level, item_sel, field_sel, field_vals, applied_vals, apply_pulse, running
  );

  modport slave (
    input  left, right, up, down, confirm, quit,
    output level, item_sel, field_sel, field_vals, applied_vals, apply_pulse, running
  );
endinterface

// File: rtl/menu_nav_ctrl.sv
// Three-level front-panel menu (MENU -> EDIT -> RUN) with edit and committed field banks.
// Optional macro MENU_KEEP_FIELDS_EN keeps one field bank per top item across MENU visits.
module menu_nav_ctrl #(
  parameter int unsigned N_ITEMS   = 3,
  parameter int unsigned N_FIELDS  = 4,
  parameter int unsigned FIELD_W   = 2,
  parameter int unsigned FIELD_MAX = 3,
  parameter int unsigned ITEM_W    = 2,
  parameter int unsigned FIDX_W    = 3
) (
  input logic             clk,
  input logic             rst_n,
  menu_nav_ctrl_if.slave  bus
);

  localparam int unsigned VALS_W = N_FIELDS * FIELD_W;
  localparam logic [FIELD_W-1:0] FMAX      = FIELD_W'(FIELD_MAX);
  localparam logic [ITEM_W-1:0]  LAST_ITEM = ITEM_W'(N_ITEMS - 1);
  localparam logic [FIDX_W-1:0]  APPLY_ROW = FIDX_W'(N_FIELDS);

  if (FIELD_MAX > (2 ** FIELD_W) - 1) begin : g_bad_field_max
    $error("FIELD_MAX does not fit in FIELD_W bits");
  end
  if (N_ITEMS < 2) begin : g_bad_n_items
    $error("N_ITEMS must be at least 2");
  end

  typedef enum logic [1:0] {StMenu = 2'd0, StEdit = 2'd1, StRun = 2'd2} state_e;
  typedef enum logic [2:0] {
    KeyNone, KeyQuit, KeyConfirm, KeyUp, KeyDown, KeyLeft, KeyRight
  } key_e;

  state_e              state_q, state_d;
  key_e                key;
  logic [ITEM_W-1:0]   item_q, item_d;
  logic [FIDX_W-1:0]   fsel_q, fsel_d;
  logic [VALS_W-1:0]   field_q, field_d;
  logic [VALS_W-1:0]   applied_q, applied_d;
  logic                pulse_q, pulse_d;
  logic                run_q, run_d;
`ifdef MENU_KEEP_FIELDS_EN
  logic [VALS_W-1:0]   bank_q [N_ITEMS];
  logic [VALS_W-1:0]   bank_d [N_ITEMS];
`endif

  function automatic logic [FIELD_W-1:0] step_val(input logic [FIELD_W-1:0] v, input logic inc);
    if (inc) return (v == FMAX) ? '0 : v + 1'b1;
    else     return (v == '0) ? FMAX : v - 1'b1;
  endfunction

  // Reduce simultaneous key pulses to the single highest-priority key; opposing pairs cancel.
  always_comb begin
    key = KeyNone;
    if (bus.quit)                     key = KeyQuit;
    else if (bus.confirm)             key = KeyConfirm;
    else if (bus.up ^ bus.down)       key = bus.up ? KeyUp : KeyDown;
    else if (bus.left ^ bus.right)    key = bus.left ? KeyLeft : KeyRight;
  end

  // Next-state and register updates for the menu FSM.
  always_comb begin
    state_d   = state_q;
    item_d    = item_q;
    fsel_d    = fsel_q;
    field_d   = field_q;
    applied_d = applied_q;
    pulse_d   = 1'b0;
`ifdef MENU_KEEP_FIELDS_EN
    bank_d    = bank_q;
`endif
    unique case (state_q)
      StMenu: begin
        case (key)
          KeyLeft:  item_d = (item_q == '0) ? LAST_ITEM : item_q - 1'b1;
          KeyRight: item_d = (item_q == LAST_ITEM) ? '0 : item_q + 1'b1;
          KeyConfirm: begin
            state_d = StEdit;
            fsel_d  = '0;
`ifdef MENU_KEEP_FIELDS_EN
            for (int unsigned i = 0; i < N_ITEMS; i++) begin
              if (item_q == ITEM_W'(i)) field_d = bank_q[i];
            end
`endif
          end
          default: ;
        endcase
      end
      StEdit, StRun: begin
        case (key)
          KeyUp:   fsel_d = (fsel_q == '0) ? APPLY_ROW : fsel_q - 1'b1;
          KeyDown: fsel_d = (fsel_q == APPLY_ROW) ? '0 : fsel_q + 1'b1;
          KeyLeft, KeyRight: begin
            // Apply row never matches a field index, so it is left untouched.
            for (int unsigned k = 0; k < N_FIELDS; k++) begin
              if (fsel_q == FIDX_W'(k)) begin
                field_d[k*FIELD_W +: FIELD_W] =
                  step_val(field_q[k*FIELD_W +: FIELD_W], key == KeyRight);
              end
            end
          end
          KeyConfirm: begin
            if (fsel_q == APPLY_ROW) begin
              applied_d = field_q;
              pulse_d   = 1'b1;
              state_d   = StRun;
            end
          end
          KeyQuit: begin
            applied_d = '0;
            if (state_q == StRun) begin
              state_d = StEdit;
            end else begin
              state_d = StMenu;
              fsel_d  = '0;
`ifdef MENU_KEEP_FIELDS_EN
              for (int unsigned i = 0; i < N_ITEMS; i++) begin
                if (item_q == ITEM_W'(i)) bank_d[i] = field_q;
              end
`else
              field_d = '0;
`endif
            end
          end
          default: ;
        endcase
      end
      default: begin
        // Illegal encoding: recover to reset values.
        state_d   = StMenu;
        item_d    = '0;
        fsel_d    = '0;
        field_d   = '0;
        applied_d = '0;
`ifdef MENU_KEEP_FIELDS_EN
        for (int unsigned i = 0; i < N_ITEMS; i++) bank_d[i] = '0;
`endif
      end
    endcase
    run_d = (state_d == StRun);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StMenu;
      item_q    <= '0;
      fsel_q    <= '0;
      field_q   <= '0;
      applied_q <= '0;
      pulse_q   <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      item_q    <= item_d;
      fsel_q    <= fsel_d;
      field_q   <= field_d;
      applied_q <= applied_d;
      pulse_q   <= pulse_d;
      run_q     <= run_d;
    end
  end

`ifdef MENU_KEEP_FIELDS_EN
  // Per-item saved field banks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_ITEMS; i++) bank_q[i] <= '0;
    end else begin
      bank_q <= bank_d;
    end
  end
`endif

  assign bus.level        = state_q;
  assign bus.item_sel     = item_q;
  assign bus.field_sel    = fsel_q;
  assign bus.field_vals   = field_q;
  assign bus.applied_vals = applied_q;
  assign bus.apply_pulse  = pulse_q;
  assign bus.running      = run_q;

endmodule

// File: tb/tb_menu_nav_ctrl.sv
// Directed bench for menu_nav_ctrl: vector table plus hand sequences for async reset
// and per-item field retention.
module tb_menu_nav_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  menu_nav_ctrl_if #(.N_FIELDS(4), .FIELD_W(2), .ITEM_W(2), .FIDX_W(3)) bus ();

  menu_nav_ctrl #(
    .N_ITEMS(3), .N_FIELDS(4), .FIELD_W(2), .FIELD_MAX(3), .ITEM_W(2), .FIDX_W(3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Key vector bit order: {quit, confirm, up, down, left, right}
  localparam logic [5:0] KN = 6'b000000;
  localparam logic [5:0] KQ = 6'b100000;
  localparam logic [5:0] KC = 6'b010000;
  localparam logic [5:0] KU = 6'b001000;
  localparam logic [5:0] KD = 6'b000100;
  localparam logic [5:0] KL = 6'b000010;
  localparam logic [5:0] KR = 6'b000001;

`ifdef MENU_KEEP_FIELDS_EN
  localparam logic [7:0] KF = 8'h03;
  localparam bit KEEP = 1'b1;
`else
  localparam logic [7:0] KF = 8'h00;
  localparam bit KEEP = 1'b0;
`endif

  typedef struct {
    logic [5:0]  keys;
    logic [24:0] exp;
  } vec_t;

  vec_t vecs [44];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // {level, item_sel, field_sel, field_vals, applied_vals, apply_pulse, running}
  function automatic logic [24:0] pk(input logic [1:0] lv, input logic [1:0] it,
                                     input logic [2:0] fs, input logic [7:0] fv,
                                     input logic [7:0] av, input logic p, input logic r);
    return {lv, it, fs, fv, av, p, r};
  endfunction

  function automatic logic [24:0] obs();
    return {bus.level, bus.item_sel, bus.field_sel, bus.field_vals, bus.applied_vals,
            bus.apply_pulse, bus.running};
  endfunction

  task automatic check(input string name, input logic [24:0] act, input logic [24:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got lvl=%0d item=%0d fsel=%0d fv=%h av=%h p=%b r=%b, want lvl=%0d item=%0d fsel=%0d fv=%h av=%h p=%b r=%b",
               name, act[24:23], act[22:21], act[20:18], act[17:10], act[9:2], act[1], act[0],
               exp[24:23], exp[22:21], exp[20:18], exp[17:10], exp[9:2], exp[1], exp[0]);
    end
  endtask

  // Hold keys for exactly one rising edge, then sample 1 time unit later.
  task automatic press(input logic [5:0] k);
    {bus.quit, bus.confirm, bus.up, bus.down, bus.left, bus.right} = k;
    @(posedge clk);
    #1;
    {bus.quit, bus.confirm, bus.up, bus.down, bus.left, bus.right} = KN;
  endtask

  initial begin
    vecs[0]  = '{KN,      pk(0, 0, 0, 8'h00, 8'h00, 0, 0)};
    vecs[1]  = '{KL,      pk(0, 2, 0, 8'h00, 8'h00, 0, 0)};
    vecs[2]  = '{KR,      pk(0, 0, 0, 8'h00, 8'h00, 0, 0)};
    vecs[3]  = '{KR,      pk(0, 1, 0, 8'h00, 8'h00, 0, 0)};
    vecs[4]  = '{KC,      pk(1, 1, 0, 8'h00, 8'h00, 0, 0)};
    vecs[5]  = '{KD,      pk(1, 1, 1, 8'h00, 8'h00, 0, 0)};
    vecs[6]  = '{KR,      pk(1, 1, 1, 8'h04, 8'h00, 0, 0)};
    vecs[7]  = '{KR,      pk(1, 1, 1, 8'h08, 8'h00, 0, 0)};
    vecs[8]  = '{KR,      pk(1, 1, 1, 8'h0C, 8'h00, 0, 0)};
    vecs[9]  = '{KR,      pk(1, 1, 1, 8'h00, 8'h00, 0, 0)};
    vecs[10] = '{KU,      pk(1, 1, 0, 8'h00, 8'h00, 0, 0)};
    vecs[11] = '{KR,      pk(1, 1, 0, 8'h01, 8'h00, 0, 0)};
    vecs[12] = '{KR,      pk(1, 1, 0, 8'h02, 8'h00, 0, 0)};
    vecs[13] = '{KD,      pk(1, 1, 1, 8'h02, 8'h00, 0, 0)};
    vecs[14] = '{KD,      pk(1, 1, 2, 8'h02, 8'h00, 0, 0)};
    vecs[15] = '{KD,      pk(1, 1, 3, 8'h02, 8'h00, 0, 0)};
    vecs[16] = '{KD,      pk(1, 1, 4, 8'h02, 8'h00, 0, 0)};
    vecs[17] = '{KR,      pk(1, 1, 4, 8'h02, 8'h00, 0, 0)};
    vecs[18] = '{KC,      pk(2, 1, 4, 8'h02, 8'h02, 1, 1)};
    vecs[19] = '{KN,      pk(2, 1, 4, 8'h02, 8'h02, 0, 1)};
    vecs[20] = '{KU,      pk(2, 1, 3, 8'h02, 8'h02, 0, 1)};
    vecs[21] = '{KU,      pk(2, 1, 2, 8'h02, 8'h02, 0, 1)};
    vecs[22] = '{KU,      pk(2, 1, 1, 8'h02, 8'h02, 0, 1)};
    vecs[23] = '{KU,      pk(2, 1, 0, 8'h02, 8'h02, 0, 1)};
    vecs[24] = '{KR,      pk(2, 1, 0, 8'h03, 8'h02, 0, 1)};
    vecs[25] = '{KQ,      pk(1, 1, 0, 8'h03, 8'h00, 0, 0)};
    vecs[26] = '{KD,      pk(1, 1, 1, 8'h03, 8'h00, 0, 0)};
    vecs[27] = '{KD,      pk(1, 1, 2, 8'h03, 8'h00, 0, 0)};
    vecs[28] = '{KD,      pk(1, 1, 3, 8'h03, 8'h00, 0, 0)};
    vecs[29] = '{KD,      pk(1, 1, 4, 8'h03, 8'h00, 0, 0)};
    vecs[30] = '{KC,      pk(2, 1, 4, 8'h03, 8'h03, 1, 1)};
    vecs[31] = '{KC,      pk(2, 1, 4, 8'h03, 8'h03, 1, 1)};
    vecs[32] = '{KN,      pk(2, 1, 4, 8'h03, 8'h03, 0, 1)};
    vecs[33] = '{KD,      pk(2, 1, 0, 8'h03, 8'h03, 0, 1)};
    vecs[34] = '{KU,      pk(2, 1, 4, 8'h03, 8'h03, 0, 1)};
    vecs[35] = '{KQ,      pk(1, 1, 4, 8'h03, 8'h00, 0, 0)};
    vecs[36] = '{KQ,      pk(0, 1, 0, KF,    8'h00, 0, 0)};
    vecs[37] = '{KC | KL, pk(1, 1, 0, KF,    8'h00, 0, 0)};
    vecs[38] = '{KU | KD, pk(1, 1, 0, KF,    8'h00, 0, 0)};
    vecs[39] = '{KL | KR, pk(1, 1, 0, KF,    8'h00, 0, 0)};
    vecs[40] = '{KC,      pk(1, 1, 0, KF,    8'h00, 0, 0)};
    vecs[41] = '{KQ | KC, pk(0, 1, 0, KF,    8'h00, 0, 0)};
    vecs[42] = '{KR,      pk(0, 2, 0, KF,    8'h00, 0, 0)};
    vecs[43] = '{KU,      pk(0, 2, 0, KF,    8'h00, 0, 0)};

    rst_n = 1'b0;
    {bus.quit, bus.confirm, bus.up, bus.down, bus.left, bus.right} = KN;
    #12;
    check("reset_state", obs(), pk(0, 0, 0, 8'h00, 8'h00, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 44; i++) begin
      press(vecs[i].keys);
      check($sformatf("vec%0d", i), obs(), vecs[i].exp);
    end

    // Reach RUN on item 2, then drop reset mid-cycle while apply_pulse is high.
    press(KC);
    press(KD); press(KD); press(KD); press(KD);
    press(KC);
    check("run_entry_item2", obs(), pk(2, 2, 4, 8'h00, 8'h00, 1, 1));
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_clears", obs(), pk(0, 0, 0, 8'h00, 8'h00, 0, 0));
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("after_reset_edge", obs(), pk(0, 0, 0, 8'h00, 8'h00, 0, 0));

    // Field retention across MENU visits (cleared when the feature is off).
    press(KC);
    press(KR);
    check("item0_f0_set", obs(), pk(1, 0, 0, 8'h01, 8'h00, 0, 0));
    press(KQ);
    check("item0_quit", obs(), pk(0, 0, 0, KEEP ? 8'h01 : 8'h00, 8'h00, 0, 0));
    press(KR);
    press(KC);
    check("item1_enter", obs(), pk(1, 1, 0, 8'h00, 8'h00, 0, 0));
    press(KD);
    press(KR);
    check("item1_f1_set", obs(), pk(1, 1, 1, 8'h04, 8'h00, 0, 0));
    press(KQ);
    press(KL);
    press(KC);
    check("item0_reenter", obs(), pk(1, 0, 0, KEEP ? 8'h01 : 8'h00, 8'h00, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/menu_nav_ctrl.md
Name: menu_nav_ctrl

Overview:
Parametrised menu navigation controller for the front panel. It consumes single-cycle key-release pulses from the button debouncers and runs a three-level menu: top item select, field edit, then run. It holds the edit and committed field banks that drive sig_gen and similar engines, and exports the menu position to hdmi_dis. It generalises the inline menu logic in the top level to N items, N fields and arbitrary field width and range, and adds an explicit apply/commit handshake.

Parameters:
- N_ITEMS, 3: number of top-level menu items; item_sel counts 0..N_ITEMS-1.
- N_FIELDS, 4: editable fields per item. Field index N_FIELDS is the "apply" row.
- FIELD_W, 2: bit width of each field value.
- FIELD_MAX, 3: maximum field value, inclusive; must be at most 2^FIELD_W-1.
- ITEM_W, 2: width of item_sel; must satisfy 2^ITEM_W >= N_ITEMS.
- FIDX_W, 3: width of field_sel; must satisfy 2^FIDX_W >= N_FIELDS+1.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- left, input, 1: key pulse, one clk wide.
- right, input, 1: key pulse.
- up, input, 1: key pulse.
- down, input, 1: key pulse.
- confirm, input, 1: key pulse.
- quit, input, 1: key pulse.
- level, output, 2: menu level. 0 = MENU, 1 = EDIT, 2 = RUN.
- item_sel, output, ITEM_W: highlighted or active top item.
- field_sel, output, FIDX_W: highlighted field row in EDIT.
- field_vals, output, N_FIELDS*FIELD_W: edit bank. Field k occupies bits [k*FIELD_W +: FIELD_W].
- applied_vals, output, N_FIELDS*FIELD_W: committed bank consumed by engines.
- apply_pulse, output, 1: one-cycle strobe when applied_vals is updated.
- running, output, 1: high while in RUN.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state = MENU.
  - level, item_sel, field_sel, field_vals, applied_vals, apply_pulse and running all 0.
  - All outputs are registered. Every key takes effect on the clk edge where it is sampled high, so outputs change 1 cycle after the key.
- Key priority when several are high in the same cycle: quit > confirm > up/down > left/right.
  - up and down together: both ignored.
  - left and right together: both ignored.
  - Lower-priority keys in that cycle are discarded.
- MENU:
  - left: item_sel-1, wrapping 0 -> N_ITEMS-1.
  - right: item_sel+1, wrapping N_ITEMS-1 -> 0.
  - confirm: go to EDIT with field_sel = 0.
  - up, down and quit: no effect.
- EDIT:
  - up: field_sel-1, wrapping 0 -> N_FIELDS.
  - down: field_sel+1, wrapping N_FIELDS -> 0.
  - left/right on a field row (field_sel < N_FIELDS): decrement/increment that field. Wrap 0 <-> FIELD_MAX. Other fields are unchanged.
  - left/right on the apply row: no effect.
  - confirm on a field row: no effect.
  - confirm on the apply row: applied_vals <= field_vals, apply_pulse = 1 for one cycle, running = 1, go to RUN.
  - quit: go to MENU. field_sel = 0. Field handling follows Optional Feature. applied_vals is cleared to 0 and running stays 0.
- RUN:
  - up/down/left/right edit field_sel and field_vals exactly as in EDIT.
  - applied_vals holds until the next confirm on the apply row. That confirm re-commits and pulses apply_pulse, and the state stays RUN.
  - quit: go to EDIT. running = 0. applied_vals is cleared to 0. field_vals and field_sel are kept.
- item_sel is frozen outside MENU.
- Unreachable state encoding: the next clk returns to MENU with reset values.
- Reset asserted mid-operation: all outputs clear immediately, without waiting for clk. No apply_pulse is generated.
- Parameter checking: the block must fail elaboration when FIELD_MAX > 2^FIELD_W-1 or when N_ITEMS < 2.

Optional Feature:
- Macro: MENU_KEEP_FIELDS_EN.
- Defined:
  - field_vals is stored per item as N_ITEMS banks.
  - quit to MENU retains each bank.
  - Entering EDIT on item i restores bank i to field_vals.
- Undefined:
  - A single shared bank is used.
  - quit to MENU clears field_vals to 0.

Test Plan:
- Reset, then left pulse -> item_sel = 2 (N_ITEMS=3). Then right x2 -> item_sel = 1.
- confirm, down, then right x4 -> level = 1, field_sel = 1, field 1 value 3 -> 0 wrap seen, field_vals = 8'b00_00_00_00 after the 4th pulse.
- Set field0 = 2, then down x4 to the apply row, then confirm -> apply_pulse high exactly 1 cycle, applied_vals[1:0] = 2, running = 1, level = 2.
- In RUN: right on field0, then quit -> level = 1, running = 0, applied_vals = 0, field0 = 3 kept.
- confirm and left in the same cycle in MENU -> enters EDIT, item_sel unchanged. up and down in the same cycle -> field_sel unchanged.
- Drop rst_n mid-cycle while in RUN -> all outputs 0 before the next clk edge. With MENU_KEEP_FIELDS_EN defined, quit to MENU and re-enter the item -> previous field values restored.
